// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed-latency single-cycle response.
// Optional request checking (range, alignment, mask, ren/wen) is enabled by `DMEM_RESP_ERR_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_mask,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] addr_q;
  logic        ren_q;
  logic        wen_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;

  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic             accept_c;
  logic             commit_c;
  logic [31:0]      cur_addr_c;
  logic             cur_ren_c;
  logic             cur_wen_c;
  logic [31:0]      cur_wdata_c;
  logic [3:0]       cur_mask_c;
  logic [IDX_W-1:0] idx_c;
  logic [31:0]      lanes_c;
  logic             err_c;

  assign o_req_ready = (state_q != S_WAIT);
  assign accept_c    = i_req_valid & o_req_ready;

  // Next state; the counter only moves while waiting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_RESP;
        end
      end
      default: begin
        if (accept_c) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Entering RESP from WAIT commits the latched request; otherwise (LATENCY==1) the live one.
  assign commit_c    = (state_d == S_RESP);
  assign cur_addr_c  = (state_q == S_WAIT) ? addr_q  : i_req_addr;
  assign cur_ren_c   = (state_q == S_WAIT) ? ren_q   : i_req_ren;
  assign cur_wen_c   = (state_q == S_WAIT) ? wen_q   : i_req_wen;
  assign cur_wdata_c = (state_q == S_WAIT) ? wdata_q : i_req_wdata;
  assign cur_mask_c  = (state_q == S_WAIT) ? mask_q  : i_req_mask;

  assign idx_c   = IDX_W'((cur_addr_c - BASE_ADDR) >> 2);
  assign lanes_c = {{8{cur_mask_c[3]}}, {8{cur_mask_c[2]}}, {8{cur_mask_c[1]}}, {8{cur_mask_c[0]}}};

`ifdef DMEM_RESP_ERR_EN
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  logic [32:0] off_c;
  // 33-bit offset so addresses below BASE_ADDR land above SPAN.
  assign off_c = {1'b0, cur_addr_c} - {1'b0, BASE_ADDR};
  assign err_c = (off_c >= SPAN) | (cur_addr_c[1:0] != 2'b00) |
                 (cur_mask_c == 4'b0000) | (cur_ren_c == cur_wen_c);
`else
  assign err_c = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= commit_c;
      if (commit_c) begin
        rsp_err_q   <= err_c;
        rsp_rdata_q <= (err_c | cur_wen_c | ~cur_ren_c) ? 32'h0 : (mem_q[idx_c] & lanes_c);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept_c) begin
      addr_q  <= i_req_addr;
      ren_q   <= i_req_ren;
      wen_q   <= i_req_wen;
      wdata_q <= i_req_wdata;
      mask_q  <= i_req_mask;
    end
  end

  // Memory array is not reset; a reset edge suppresses the pending commit.
  always_ff @(posedge i_clk) begin
    if (!i_rst && commit_c && cur_wen_c && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_mask_c[b]) begin
          mem_q[idx_c][8*b +: 8] <= cur_wdata_c[8*b +: 8];
        end
      end
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder side of the hart data-memory port, built as the "realistic memory" that replaces the combinational dmem model. It accepts one read or write request at a time through a valid/ready handshake and returns a one-cycle response after a fixed, parameterized latency. Writes use the hart's byte-lane mask. It sits between the hart's dmem request logic and the testbench or SoC memory map.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, ≥ 4.
- `BASE_ADDR`, 32'h00000000: byte address of word 0; 4-byte aligned.
- `LATENCY`, 2: edges from request acceptance to response; legal range 1–16.

- `i_clk` input 1: global clock.
- `i_rst` input 1: reset, synchronous and active-high.
- `i_req_valid` input 1: request present.
- `o_req_ready` output 1: responder can accept a request this cycle.
- `i_req_addr` input 32: byte address; expected to be word aligned.
- `i_req_ren` input 1: read request.
- `i_req_wen` input 1: write request.
- `i_req_wdata` input 32: write data, already shifted into its byte lanes.
- `i_req_mask` input 4: byte lanes to read or write; bit n selects bits [8n+7:8n].
- `o_rsp_valid` output 1: response valid for exactly one cycle.
- `o_rsp_rdata` output 32: read data; unmasked lanes are 0.
- `o_rsp_err` output 1: request was rejected; valid when `o_rsp_valid` is high.

## Operation
- Accept a request on a rising edge where `i_req_valid & o_req_ready`. Latch addr, ren, wen, wdata and mask at that edge.
- Word index = `((addr - BASE_ADDR) >> 2)` truncated to `log2(DEPTH_WORDS)` bits.
- States:
  - IDLE: `o_req_ready=1`.
  - WAIT: down-counter loaded with `LATENCY-1`; `o_req_ready=0`.
  - RESP: `o_rsp_valid=1`, `o_req_ready=1`.
- Transitions:
  - On acceptance, go to RESP if `LATENCY==1`; otherwise go to WAIT.
  - WAIT goes to RESP on the edge where the counter reaches 1.
  - RESP goes to IDLE, or to WAIT/RESP again if a new request is accepted in the RESP cycle (back-to-back).
- Commit edge: the edge that enters RESP.
  - A write updates the selected word at the commit edge. Only lanes with mask=1 are written; other lanes are unchanged.
  - A read samples the memory word at the commit edge into `o_rsp_rdata`, with unmasked lanes forced to 0.
  - Because a write commits before its response, a read accepted in the write's RESP cycle sees the new data.
- Outside RESP, `o_rsp_rdata` and `o_rsp_err` hold their last values. `o_rsp_valid=0`.
- The response has no backpressure; the requester must take it in the RESP cycle.
- Illegal combinations, when `ERR_EN` is off:
  - `ren & wen` is treated as a write.
  - `!ren & !wen` gives a response with no memory effect and rdata 0.
  - Out-of-range addresses wrap modulo the depth.

## Timing
- Reset values:
  - State: IDLE.
  - `o_req_ready=1`, `o_rsp_valid=0`, `o_rsp_rdata=0`, `o_rsp_err=0`.
  - Counter: 0.
  - Memory contents are not reset.
- Latency:
  - A request accepted at edge k gives `o_rsp_valid=1` in the cycle after edge k+LATENCY-1. For `LATENCY=1`, that is the cycle right after edge k.
  - With `LATENCY=1`, sustained back-to-back traffic reaches 1 request/cycle.
  - With `LATENCY=L`, throughput is one request per L cycles.
- Reset asserted mid-operation: the pending request is dropped at that edge. No write commits and no response is produced.
- `i_req_*` are ignored whenever `o_req_ready=0`.
- All outputs are registered except `o_req_ready`, which is decoded from the state register.

## Configuration
- `DMEM_RESP_ERR_EN` defined:
  - Reject a request if any of these holds: addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS), `addr[1:0]!=0`, `mask==0`, or `ren==wen`.
  - A rejected request gets `o_rsp_err=1` and `o_rsp_rdata=0`, with no memory write. Latency is unchanged.
- `DMEM_RESP_ERR_EN` undefined:
  - `o_rsp_err` is tied to 0.
  - Illegal combinations follow the wrap/priority rules in Operation.

## Test plan
- Reset, then `LATENCY=2`: write 0xDEADBEEF, mask 4'b1111, to addr 0x10. Then read 0x10 with mask 4'b1111. Required: each `o_rsp_valid` comes 2 cycles after acceptance, and the read returns 0xDEADBEEF.
- Byte write 0x00AB0000 with mask 4'b0100 over word 0x11223344, then a full read. Required: 0x11AB3344. A read with mask 4'b1100 returns 0x11AB0000.
- `LATENCY=1` back-to-back: write 0x5 to 0x20, and in the RESP cycle issue a read of 0x20. Required: `o_req_ready` stays 1 and the read returns 0x00000005 one cycle later.
- Assert `i_req_valid` while in WAIT. Required: `o_req_ready=0`, the request is ignored, and exactly one response is produced.
- Reset mid-WAIT after a write of 0xFFFFFFFF to 0x30 (prior value 0x0). Required: no `o_rsp_valid`, and a later read of 0x30 returns 0x00000000.
- With `DMEM_RESP_ERR_EN` defined:
  - Read addr 0x2 returns `o_rsp_err=1`, rdata 0.
  - Write to BASE_ADDR+4*DEPTH_WORDS returns `o_rsp_err=1` and leaves word 0 unchanged.
  - `ren=wen=1` returns `o_rsp_err=1`.
